// File: rtl/data_ram_v2_if.sv
// rtl/data_ram_v2_if.sv - access bus for data_ram_v2: user requests in, read data and status out
interface data_ram_v2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0]   dataC;
  logic [ADDR_WIDTH-1:0]   address;
  logic                    writeEnable;
  logic [DATA_WIDTH/8-1:0] byteEnable;
  logic                    readEnable;
  logic                    clearRequest;
  logic [DATA_WIDTH-1:0]   dataRAMOutput;
  logic                    ready;
  logic                    addressError;

  modport master (
    output dataC, address, writeEnable, byteEnable, readEnable, clearRequest,
    input  dataRAMOutput, ready, addressError
  );

  modport slave (
    input  dataC, address, writeEnable, byteEnable, readEnable, clearRequest,
    output dataRAMOutput, ready, addressError
  );
endinterface

// File: rtl/data_ram_v2.sv
// rtl/data_ram_v2.sv - byte-maskable word RAM with a clear-sweep engine and sticky range checking
module data_ram_v2 #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 10,
  parameter int                    DEPTH           = 256,
  parameter int                    READ_REGISTERED = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE     = '0
) (
  input logic          clock,
  input logic          reset,
  data_ram_v2_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]            state;
  logic [PTR_W-1:0]      clearPtr;
  logic                  addressError;
  logic [DATA_WIDTH-1:0] regOut;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wordIdx;
  logic                  inRange;
  logic                  isIdle;
  logic                  accepting;
  logic                  userWrite;
  logic                  outOfRange;
  logic [DATA_WIDTH-1:0] memWord;
  logic [DATA_WIDTH-1:0] mergedWord;
  logic [DATA_WIDTH-1:0] readWord;

  // Range test is done one bit wider so DEPTH == 2^ADDR_WIDTH does not overflow.
  assign inRange   = ({1'b0, bus.address} < (ADDR_WIDTH + 1)'(DEPTH));
  assign wordIdx   = bus.address[PTR_W-1:0];
  assign isIdle    = (state == IDLE);
  assign accepting = isIdle && !bus.clearRequest;
  assign memWord   = mem[wordIdx];
  assign userWrite = accepting && bus.writeEnable && inRange;
  assign outOfRange = accepting && !inRange &&
                      (bus.writeEnable || ((READ_REGISTERED != 0) && bus.readEnable));

  always_comb begin
    mergedWord = memWord;
    for (int b = 0; b < BYTES; b++) begin
      if (bus.byteEnable[b]) mergedWord[8*b +: 8] = bus.dataC[8*b +: 8];
    end
  end

  // A same-edge write targets the same word as the read, so write-first is the merged word.
  assign readWord = userWrite ? mergedWord : memWord;

  always_ff @(posedge clock) begin
    if (reset) begin
      if (!isIdle) begin
        mem[clearPtr] <= CLEAR_VALUE;
      end else if (userWrite) begin
        mem[wordIdx] <= mergedWord;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= CLEAR;
      clearPtr     <= '0;
      addressError <= 1'b0;
      regOut       <= '0;
    end else if (!isIdle) begin
      if (clearPtr == PTR_W'(DEPTH - 1)) begin
        state    <= IDLE;
        clearPtr <= '0;
      end else begin
        clearPtr <= clearPtr + 1'b1;
      end
    end else if (bus.clearRequest) begin
      state        <= CLEAR;
      clearPtr     <= '0;
      addressError <= 1'b0;
      regOut       <= '0;
    end else begin
      if (outOfRange) addressError <= 1'b1;
      if ((READ_REGISTERED != 0) && bus.readEnable) begin
        regOut <= inRange ? readWord : '0;
      end
    end
  end

  assign bus.ready        = isIdle;
  assign bus.addressError = addressError;
  assign bus.dataRAMOutput = (READ_REGISTERED != 0) ? regOut :
                             ((isIdle && inRange) ? memWord : '0);
endmodule

// File: tb/tb_data_ram_v2.sv
// tb/tb_data_ram_v2.sv - scoreboard bench: combinational and registered-read instances driven in lockstep
module tb_data_ram_v2;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 256;

  localparam int SEL_OUT_C = 0;
  localparam int SEL_OUT_R = 1;
  localparam int SEL_RDY_C = 2;
  localparam int SEL_RDY_R = 3;
  localparam int SEL_ERR_C = 4;
  localparam int SEL_ERR_R = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0]   dataC;
  logic [AW-1:0]   address;
  logic            writeEnable;
  logic [DW/8-1:0] byteEnable;
  logic            readEnable;
  logic            clearRequest;

  data_ram_v2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busC ();
  data_ram_v2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busR ();

  assign busC.dataC = dataC;             assign busR.dataC = dataC;
  assign busC.address = address;         assign busR.address = address;
  assign busC.writeEnable = writeEnable; assign busR.writeEnable = writeEnable;
  assign busC.byteEnable = byteEnable;   assign busR.byteEnable = byteEnable;
  assign busC.readEnable = readEnable;   assign busR.readEnable = readEnable;
  assign busC.clearRequest = clearRequest;
  assign busR.clearRequest = clearRequest;

  data_ram_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                .READ_REGISTERED(0), .CLEAR_VALUE(32'h0))
    dutC (.clock(clock), .reset(reset), .bus(busC));

  data_ram_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                .READ_REGISTERED(1), .CLEAR_VALUE(32'h0))
    dutR (.clock(clock), .reset(reset), .bus(busR));

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        cur;
  logic [31:0] act;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SEL_OUT_C: return busC.dataRAMOutput;
      SEL_OUT_R: return busR.dataRAMOutput;
      SEL_RDY_C: return {31'b0, busC.ready};
      SEL_RDY_R: return {31'b0, busR.ready};
      SEL_ERR_C: return {31'b0, busC.addressError};
      default:   return {31'b0, busR.addressError};
    endcase
  endfunction

  // Monitor: every expectation queued since the last falling edge is compared here.
  always @(negedge clock) begin
    while (sbQ.size() > 0) begin
      cur = sbQ.pop_front();
      act = pick(cur.sel);
      checks++;
      if (act !== cur.exp) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic checkNow(input string n, input int sel, input logic [31:0] v);
    logic [31:0] got;
    got = pick(sel);
    checks++;
    if (got !== v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, got, v);
    end
  endtask

  task automatic pushExp(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.exp  = v;
    sbQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      if (i == 1 || i == DEPTH - 1) pushExp({tag, "_ready_lo"}, SEL_RDY_C, 32'd0);
      if (i == DEPTH) begin
        checkNow({tag, "_ready_hi"}, SEL_RDY_C, 32'd1);
        checkNow({tag, "_ready_hiR"}, SEL_RDY_R, 32'd1);
      end
    end
  endtask

  initial begin
    dataC = '0; address = '0; writeEnable = 1'b0; byteEnable = '0;
    readEnable = 1'b0; clearRequest = 1'b0; reset = 1'b0;

    step();
    checkNow("rst_readyC", SEL_RDY_C, 32'd0);
    checkNow("rst_readyR", SEL_RDY_R, 32'd0);
    checkNow("rst_errC", SEL_ERR_C, 32'd0);
    checkNow("rst_errR", SEL_ERR_R, 32'd0);
    checkNow("rst_outR", SEL_OUT_R, 32'd0);
    step();
    step();
    reset = 1'b1;
    sweep("init");

    address = 10'd0;   pushExp("init_rd0", SEL_OUT_C, 32'd0);   step();
    address = 10'd128; pushExp("init_rd128", SEL_OUT_C, 32'd0); step();
    address = 10'd255; pushExp("init_rd255", SEL_OUT_C, 32'd0); step();

    address = 10'd5; dataC = 32'hAABBCCDD; byteEnable = 4'b1111; writeEnable = 1'b1;
    step();
    dataC = 32'h11223344; byteEnable = 4'b0101;
    pushExp("wr_full", SEL_OUT_C, 32'hAABBCCDD);
    step();
    dataC = 32'hFFFFFFFF; byteEnable = 4'b0000;
    pushExp("wr_merge", SEL_OUT_C, 32'hAA22CC44);
    step();
    writeEnable = 1'b0;
    pushExp("wr_zero_mask", SEL_OUT_C, 32'hAA22CC44);
    pushExp("wr_zero_mask_err", SEL_ERR_C, 32'd0);
    step();
    address = 10'd261;
    pushExp("rd_oor_comb", SEL_OUT_C, 32'd0);
    step();

    address = 10'd7; dataC = 32'hDEADBEEF; byteEnable = 4'b1111;
    writeEnable = 1'b1; readEnable = 1'b1;
    step();
    writeEnable = 1'b0; readEnable = 1'b0; address = 10'd5;
    pushExp("rr_write_first", SEL_OUT_R, 32'hDEADBEEF);
    step();
    readEnable = 1'b1;
    pushExp("rr_hold", SEL_OUT_R, 32'hDEADBEEF);
    step();
    readEnable = 1'b0;
    pushExp("rr_load5", SEL_OUT_R, 32'hAA22CC44);
    step();

    address = 10'd300; dataC = 32'h12345678; byteEnable = 4'b1111; writeEnable = 1'b1;
    step();
    writeEnable = 1'b0; address = 10'd44;
    pushExp("oor_errC", SEL_ERR_C, 32'd1);
    pushExp("oor_errR", SEL_ERR_R, 32'd1);
    pushExp("oor_no_alias", SEL_OUT_C, 32'd0);
    step();
    step();
    step();
    pushExp("oor_sticky", SEL_ERR_C, 32'd1);
    step();

    clearRequest = 1'b1; writeEnable = 1'b1; address = 10'd9;
    dataC = 32'hCAFEF00D; byteEnable = 4'b1111;
    step();
    clearRequest = 1'b0; address = 10'd300; dataC = 32'hFFFFFFFF; readEnable = 1'b1;
    pushExp("clr_ready_lo0", SEL_RDY_C, 32'd0);
    pushExp("clr_outR_zero", SEL_OUT_R, 32'd0);
    pushExp("clr_err_cleared", SEL_ERR_C, 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      if (i == 129) address = 10'd200;
      step();
      if (i == DEPTH - 1) pushExp("clr_ready_lo", SEL_RDY_C, 32'd0);
      if (i == DEPTH) begin
        writeEnable = 1'b0; readEnable = 1'b0;
        checkNow("clr_ready_hi", SEL_RDY_C, 32'd1);
        checkNow("clr_ready_hiR", SEL_RDY_R, 32'd1);
      end
    end
    address = 10'd9;
    pushExp("clr_write_dropped", SEL_OUT_C, 32'd0);
    pushExp("clr_errC", SEL_ERR_C, 32'd0);
    pushExp("clr_errR", SEL_ERR_R, 32'd0);
    step();
    address = 10'd200;
    pushExp("clr_ignored_write", SEL_OUT_C, 32'd0);
    pushExp("clr_outR_held", SEL_OUT_R, 32'd0);
    step();

    address = 10'd3; dataC = 32'h5A5A5A5A; byteEnable = 4'b1111; writeEnable = 1'b1;
    step();
    writeEnable = 1'b0; readEnable = 1'b1;
    step();
    address = 10'd300;
    pushExp("rr_rd3", SEL_OUT_R, 32'h5A5A5A5A);
    step();
    readEnable = 1'b0;
    pushExp("rr_oor_zero", SEL_OUT_R, 32'd0);
    pushExp("rr_oor_errR", SEL_ERR_R, 32'd1);
    pushExp("rr_oor_errC", SEL_ERR_C, 32'd0);
    step();

    address = 10'd3;
    clearRequest = 1'b1;
    step();
    clearRequest = 1'b0;
    for (int i = 1; i <= 99; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    pushExp("mid_rst_readyC", SEL_RDY_C, 32'd0);
    pushExp("mid_rst_readyR", SEL_RDY_R, 32'd0);
    pushExp("mid_rst_errR", SEL_ERR_R, 32'd0);
    sweep("mid_rst");
    pushExp("mid_rst_rd3", SEL_OUT_C, 32'd0);
    step();

    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_ram_v2.md
DATA_RAM_V2 -- requirements
Module: data_ram_v2

Interface
REQ-001 Parameter DATA_WIDTH, 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, 10, address port width.
REQ-003 Parameter DEPTH, 256, number of words; SHALL satisfy DEPTH <= 2^ADDR_WIDTH.
REQ-004 Parameter READ_REGISTERED, 0, read mode: 0 = combinational read, 1 = one-cycle registered read.
REQ-005 Parameter CLEAR_VALUE, 0, word value written by the clear engine.
REQ-006 clock  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 dataC  in  DATA_WIDTH  write data.
REQ-009 address  in  ADDR_WIDTH  word address for reads and writes.
REQ-010 writeEnable  in  1  write request.
REQ-011 byteEnable  in  DATA_WIDTH/8  per-byte write mask; bit i covers dataC[8i+7:8i].
REQ-012 readEnable  in  1  read capture strobe; used only when READ_REGISTERED=1.
REQ-013 clearRequest  in  1  single-cycle request to re-run the clear sweep.
REQ-014 dataRAMOutput  out  DATA_WIDTH  read data.
REQ-015 ready  out  1  high when the array is accessible (state IDLE).
REQ-016 addressError  out  1  sticky flag for an out-of-range access.

Function
REQ-017 The FSM SHALL have exactly two states: CLEAR and IDLE.
REQ-018 In CLEAR, each rising edge SHALL write CLEAR_VALUE to word clearPtr and increment clearPtr.
REQ-019 On the edge that writes word DEPTH-1, the FSM SHALL go to IDLE; ready SHALL be 1 from that edge on.
REQ-020 A full sweep SHALL take exactly DEPTH edges.
REQ-021 In CLEAR, writeEnable, readEnable and clearRequest SHALL be ignored; no user write SHALL occur and addressError SHALL NOT change.
REQ-022 In IDLE with clearRequest=1, the next edge SHALL enter CLEAR with clearPtr=0 and ready=0.
REQ-023 In IDLE, if clearRequest and writeEnable are both high, clearRequest SHALL win and the write SHALL be dropped.
REQ-024 In IDLE, a write with address < DEPTH SHALL update only the bytes whose byteEnable bit is 1; all other bytes SHALL be kept.
REQ-025 A write with byteEnable all zero SHALL leave the word unchanged and SHALL NOT be an error.
REQ-026 Out-of-range access means, in IDLE, address >= DEPTH with writeEnable=1, or with readEnable=1 when READ_REGISTERED=1.
REQ-027 An out-of-range write SHALL be suppressed, with no aliasing or wrap-around of the address.
REQ-028 An out-of-range access SHALL set addressError at the next edge.
REQ-029 addressError SHALL stay set until reset or an accepted clearRequest clears it.
REQ-030 READ_REGISTERED=0: dataRAMOutput SHALL equal mem[address] combinationally when ready=1 and address < DEPTH, else 0.
REQ-031 READ_REGISTERED=0: after a write edge, the output SHALL show the newly written data.
REQ-032 READ_REGISTERED=1: with readEnable=1 in IDLE, the edge SHALL load dataRAMOutput with mem[address].
REQ-033 READ_REGISTERED=1, same address written on the same edge: the load SHALL be write-first, i.e. the byte-merged new word.
REQ-034 READ_REGISTERED=1: an out-of-range read SHALL load 0.
REQ-035 READ_REGISTERED=1: with readEnable=0, and throughout CLEAR, dataRAMOutput SHALL hold its value.
REQ-036 READ_REGISTERED=1: on entry to CLEAR via clearRequest, dataRAMOutput SHALL load 0.

Reset
REQ-037 When reset=0 at an edge: state CLEAR, clearPtr 0, ready 0, addressError 0, registered dataRAMOutput 0.
REQ-038 reset=0 mid-sweep SHALL restart the sweep from word 0 after reset is released.
REQ-039 Array contents are unspecified while reset is held, but SHALL all equal CLEAR_VALUE when ready first rises.

Verification
REQ-040 Reset held low 3 edges, then released (DEPTH=256) -> ready=0 for 256 edges, then 1; reads of addresses 0, 128 and 255 return 0.
REQ-041 Write 0xAABBCCDD to address 5 with byteEnable=1111, then write 0x11223344 with byteEnable=0101 -> mem[5]=0xAA22CC44.
REQ-042 READ_REGISTERED=1, same edge: write 0xDEADBEEF with byteEnable=1111 and readEnable to address 7 -> dataRAMOutput=0xDEADBEEF after that edge.
REQ-043 Write to address 300 (DEPTH=256) -> addressError=1 at the next edge; mem[44] unchanged; flag stays 1 until clearRequest.
REQ-044 clearRequest together with a write to address 9 -> write dropped; ready low 256 edges; then mem[9]=CLEAR_VALUE and addressError=0.
REQ-045 reset pulsed low at sweep edge 100 -> ready rises exactly 256 edges after reset is released.
